// File: rtl/can_tx_frame_fetch.sv
// CAN Tx frame fetch: pops one frame word from the Tx FIFO, unpacks it,
// offers it to the bit engine and retries on error up to MAX_RETRY times.
module can_tx_frame_fetch #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_RETRY  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_underflow,
  input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
  output logic                  o_fifo_r_en,
  output logic                  o_frame_valid,
  input  logic                  i_tx_ready,
  input  logic                  i_tx_done,
  input  logic                  i_tx_err,
  input  logic                  i_abort,
  output logic [28:0]           o_id,
  output logic                  o_ide,
  output logic                  o_rtr,
  output logic [3:0]            o_dlc,
  output logic [63:0]           o_data,
  output logic                  o_busy,
  output logic                  o_sent,
  output logic                  o_dropped,
  output logic [3:0]            o_retry_cnt,
  output logic [CNT_WIDTH-1:0]  o_sent_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_OFFER, S_WAIT
  } state_t;

  state_t r_state, w_next;
  logic   w_cap, w_drop, w_sent, w_retry_inc;

  logic                 r_fifo_r_en, r_frame_valid, r_busy;
  logic                 r_sent, r_dropped;
  logic [28:0]          r_id;
  logic                 r_ide, r_rtr;
  logic [3:0]           r_dlc, r_retry_cnt;
  logic [63:0]          r_data;
  logic [CNT_WIDTH-1:0] r_sent_count;
  logic [3:0]           w_dlc_raw;
  logic                 w_unused;

  assign w_dlc_raw = i_fifo_r_data[67:64];

  generate
    if (DATA_WIDTH > 99) begin : g_rsvd
      assign w_unused = ^i_fifo_r_data[DATA_WIDTH-1:99];
    end else begin : g_norsvd
      assign w_unused = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cap       = 1'b0;
    w_drop      = 1'b0;
    w_sent      = 1'b0;
    w_retry_inc = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (i_enable && !i_fifo_empty) w_next = S_POP;
      S_POP:
        w_next = S_LOAD;
      S_LOAD:
        if (i_fifo_underflow) begin
          w_drop = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_cap  = 1'b1;
          w_next = S_OFFER;
        end
      S_OFFER:
        if (i_abort) begin
          w_drop = 1'b1;
          w_next = S_IDLE;
        end else if (r_frame_valid && i_tx_ready) begin
          w_next = S_WAIT;
        end
      S_WAIT:
        // done outranks both abort and error in the same cycle
        if (i_tx_done) begin
          w_sent = 1'b1;
          w_next = S_IDLE;
        end else if (i_abort) begin
          w_drop = 1'b1;
          w_next = S_IDLE;
        end else if (i_tx_err) begin
          if (r_retry_cnt < 4'(MAX_RETRY)) begin
            w_retry_inc = 1'b1;
            w_next      = S_OFFER;
          end else begin
            w_drop = 1'b1;
            w_next = S_IDLE;
          end
        end
      default:
        w_next = S_IDLE;
    endcase
  end

  // Strobes follow the next state so they line up with the state itself
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fifo_r_en   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_sent        <= 1'b0;
      r_dropped     <= 1'b0;
      r_id          <= '0;
      r_ide         <= 1'b0;
      r_rtr         <= 1'b0;
      r_dlc         <= '0;
      r_data        <= '0;
      r_retry_cnt   <= '0;
      r_sent_count  <= '0;
    end else begin
      r_fifo_r_en   <= (w_next == S_POP);
      r_frame_valid <= (w_next == S_OFFER);
      r_busy        <= (w_next != S_IDLE);
      r_sent        <= w_sent;
      r_dropped     <= w_drop;
      if (w_cap) begin
        r_id        <= i_fifo_r_data[98:70];
        r_ide       <= i_fifo_r_data[69];
        r_rtr       <= i_fifo_r_data[68];
        r_dlc       <= (w_dlc_raw > 4'd8) ? 4'd8 : w_dlc_raw;
        r_data      <= i_fifo_r_data[68] ? 64'd0 : i_fifo_r_data[63:0];
        r_retry_cnt <= '0;
      end else if (w_retry_inc) begin
        r_retry_cnt <= r_retry_cnt + 4'd1;
      end
      if (w_sent) r_sent_count <= r_sent_count + 1'b1;
    end
  end

  assign o_fifo_r_en   = r_fifo_r_en;
  assign o_frame_valid = r_frame_valid;
  assign o_busy        = r_busy;
  assign o_sent        = r_sent;
  assign o_dropped     = r_dropped;
  assign o_id          = r_id;
  assign o_ide         = r_ide;
  assign o_rtr         = r_rtr;
  assign o_dlc         = r_dlc;
  assign o_data        = r_data;
  assign o_retry_cnt   = r_retry_cnt;
  assign o_sent_count  = r_sent_count;

endmodule

// File: tb/tb_can_tx_frame_fetch.sv
// Scoreboard bench for can_tx_frame_fetch: a FIFO model feeds frames, a
// monitor checks every handshake and sent/drop pulse against queued results.
module tb_can_tx_frame_fetch;

  localparam int DW = 128;
  localparam int MR = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          empty = 1'b1;
  logic          uf = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          ready = 1'b0;
  logic          done = 1'b0;
  logic          err = 1'b0;
  logic          abort = 1'b0;

  logic          r_en, valid, ide, rtr, busy, sent, dropped;
  logic [28:0]   id;
  logic [3:0]    dlc, retry;
  logic [63:0]   data;
  logic [CW-1:0] scnt;

  can_tx_frame_fetch #(.DATA_WIDTH(DW), .MAX_RETRY(MR), .CNT_WIDTH(CW)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_enable(en),
    .i_fifo_empty(empty), .i_fifo_underflow(uf), .i_fifo_r_data(rdata),
    .o_fifo_r_en(r_en), .o_frame_valid(valid), .i_tx_ready(ready),
    .i_tx_done(done), .i_tx_err(err), .i_abort(abort),
    .o_id(id), .o_ide(ide), .o_rtr(rtr), .o_dlc(dlc), .o_data(data),
    .o_busy(busy), .o_sent(sent), .o_dropped(dropped),
    .o_retry_cnt(retry), .o_sent_count(scnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [3:0]  retry;
  } offer_t;

  typedef struct {
    bit          is_sent;
    logic [15:0] cnt;
    logic [3:0]  retry;
  } ev_t;

  offer_t        q_off[$];
  ev_t           q_ev[$];
  logic [DW-1:0] fifo[$];
  int            tests = 0;
  int            fails = 0;
  int            rd_cnt = 0;
  logic [15:0]   exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (r_en && fifo.size() != 0) rdata <= fifo.pop_front();
  end

  always @(negedge clk) begin
    offer_t o;
    ev_t    e;
    empty = (fifo.size() == 0);
    if (r_en) rd_cnt++;
    if (valid && ready) begin
      if (q_off.size() == 0) chk("unexpected_offer", 64'd1, 64'd0);
      else begin
        o = q_off.pop_front();
        chk("offer_id", 64'(id), 64'(o.id));
        chk("offer_ide", 64'(ide), 64'(o.ide));
        chk("offer_rtr", 64'(rtr), 64'(o.rtr));
        chk("offer_dlc", 64'(dlc), 64'(o.dlc));
        chk("offer_data", data, o.data);
        chk("offer_retry", 64'(retry), 64'(o.retry));
      end
    end
    if (sent || dropped) begin
      if (q_ev.size() == 0) chk("unexpected_event", 64'd1, 64'd0);
      else begin
        e = q_ev.pop_front();
        chk("ev_sent", 64'(sent), 64'(e.is_sent));
        chk("ev_dropped", 64'(dropped), 64'(!e.is_sent));
        chk("ev_count", 64'(scnt), 64'(e.cnt));
        chk("ev_retry", 64'(retry), 64'(e.retry));
      end
    end
  end

  function automatic logic [DW-1:0] mk(input logic [28:0] fid,
      input logic fide, input logic frtr, input logic [3:0] fdlc,
      input logic [63:0] fdata);
    logic [DW-1:0] w;
    w = '0;
    w[63:0]    = fdata;
    w[67:64]   = fdlc;
    w[68]      = frtr;
    w[69]      = fide;
    w[98:70]   = fid;
    w[DW-1:99] = '1;
    return w;
  endfunction

  function automatic offer_t ex(input logic [28:0] fid, input logic fide,
      input logic frtr, input logic [3:0] fdlc, input logic [63:0] fdata);
    offer_t o;
    o.id = fid; o.ide = fide; o.rtr = frtr;
    o.dlc = fdlc; o.data = fdata; o.retry = 4'd0;
    return o;
  endfunction

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!valid) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  // nerr error pulses precede a done; both=1 raises err alongside the done
  task automatic run_frame(input offer_t f, input int nerr, input bit both);
    ev_t e;
    for (int k = 0; k <= nerr; k++) begin
      f.retry = 4'(k);
      q_off.push_back(f);
      wait_valid();
      @(posedge clk); #1;
      if (k < nerr) begin
        if (k == MR) begin
          e.is_sent = 1'b0; e.cnt = exp_cnt; e.retry = 4'(MR);
          q_ev.push_back(e);
        end
        err = 1'b1;
        @(posedge clk); #1;
        err = 1'b0;
        if (k == MR) return;
      end else begin
        exp_cnt++;
        e.is_sent = 1'b1; e.cnt = exp_cnt; e.retry = 4'(k);
        q_ev.push_back(e);
        done = 1'b1;
        err  = both;
        @(posedge clk); #1;
        done = 1'b0;
        err  = 1'b0;
      end
    end
  endtask

  initial begin
    offer_t f;
    int     base;
    #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ren", 64'(r_en), 64'd0);
    chk("rst_count", 64'(scnt), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;

    fifo.push_back(mk(29'h123, 1'b0, 1'b0, 4'd2, 64'hAABB << 48));
    run_frame(ex(29'h123, 1'b0, 1'b0, 4'd2, 64'hAABB000000000000), 0, 1'b0);
    chk("t1_rd_pulses", 64'(rd_cnt), 64'd1);

    fifo.push_back(mk(29'h1ABCDEF0, 1'b1, 1'b1, 4'hF, 64'h0123456789ABCDEF));
    run_frame(ex(29'h1ABCDEF0, 1'b1, 1'b1, 4'd8, 64'd0), 0, 1'b0);

    base = rd_cnt;
    fifo.push_back(mk(29'h7FF, 1'b0, 1'b0, 4'd8, 64'h1122334455667788));
    fifo.push_back(mk(29'h055, 1'b0, 1'b0, 4'd1, 64'h9900000000000000));
    run_frame(ex(29'h7FF, 1'b0, 1'b0, 4'd8, 64'h1122334455667788), MR + 1, 1'b0);
    chk("t3_no_pop_in_retry", 64'(rd_cnt), 64'(base + 1));
    chk("t3_count_held", 64'(scnt), 64'd2);
    run_frame(ex(29'h055, 1'b0, 1'b0, 4'd1, 64'h9900000000000000), 0, 1'b0);
    chk("t3_next_popped", 64'(rd_cnt), 64'(base + 2));

    base = rd_cnt;
    ready = 1'b0;
    fifo.push_back(mk(29'h0ABCDE, 1'b1, 1'b0, 4'd4, 64'hDEADBEEF00000000));
    fifo.push_back(mk(29'h321, 1'b0, 1'b0, 4'd3, 64'hCAFE010000000000));
    wait_valid();
    repeat (20) @(posedge clk);
    #1;
    chk("t4_valid_held", 64'(valid), 64'd1);
    chk("t4_id_held", 64'(id), 64'h0ABCDE);
    chk("t4_data_held", data, 64'hDEADBEEF00000000);
    chk("t4_single_pop", 64'(rd_cnt), 64'(base + 1));
    ready = 1'b1;
    run_frame(ex(29'h0ABCDE, 1'b1, 1'b0, 4'd4, 64'hDEADBEEF00000000), 0, 1'b0);
    run_frame(ex(29'h321, 1'b0, 1'b0, 4'd3, 64'hCAFE010000000000), 0, 1'b0);
    chk("t4_second_pop", 64'(rd_cnt), 64'(base + 2));

    fifo.push_back(mk(29'h444, 1'b0, 1'b0, 4'd0, 64'd0));
    run_frame(ex(29'h444, 1'b0, 1'b0, 4'd0, 64'd0), 0, 1'b1);

    f = ex(29'h600, 1'b0, 1'b0, 4'd5, 64'h0102030405000000);
    fifo.push_back(mk(29'h600, 1'b0, 1'b0, 4'd5, 64'h0102030405000000));
    q_off.push_back(f);
    wait_valid();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_count", 64'(scnt), 64'd0);
    chk("t6_id", 64'(id), 64'd0);
    chk("t6_data", data, 64'd0);
    chk("t6_dlc", 64'(dlc), 64'd0);
    exp_cnt = '0;
    base = rd_cnt;
    fifo.push_back(mk(29'h0F0F0F0, 1'b1, 1'b0, 4'd7, 64'h5555AAAA5555AA00));
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(ex(29'h0F0F0F0, 1'b1, 1'b0, 4'd7, 64'h5555AAAA5555AA00), 0, 1'b0);
    chk("t6_pop_restart", 64'(rd_cnt), 64'(base + 1));

    repeat (5) @(posedge clk);
    #1;
    chk("offers_left", 64'(q_off.size()), 64'd0);
    chk("events_left", 64'(q_ev.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
